// File: rtl/lpc_enc_pkg.sv
// Shared definitions for the LPC frame encoder: OUT_DATA field layout,
// accumulator width, the per-frame feature bundle and saturation helpers.
package lpc_enc_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int ACC_W      = 40;
  localparam int OUT_W      = 80;

  localparam int IDX_LSB    = 72;
  localparam int IDX_W      = 8;
  localparam int PEAK_LSB   = 56;
  localparam int ENERGY_LSB = 40;
  localparam int R1_LSB     = 24;
  localparam int ZC_LSB     = 8;
  localparam int FIELD_W    = 16;
  localparam int VOICED_BIT = 0;

  typedef struct packed {
    logic [FIELD_W-1:0] peak;
    logic [FIELD_W-1:0] energy;
    logic [FIELD_W-1:0] r1;
    logic [FIELD_W-1:0] zc;
    logic               voiced;
  } feat_t;

  // Unsigned clamp to 16 bits.
  function automatic logic [15:0] sat16u(input logic [ACC_W-1:0] v);
    if (v > ACC_W'(16'hFFFF)) return 16'hFFFF;
    return v[15:0];
  endfunction

  // Signed clamp to the 16-bit two's complement range.
  function automatic logic [15:0] sat16s(input logic signed [ACC_W-1:0] v);
    if (v > 40'sd32767) return 16'h7FFF;
    if (v < -40'sd32768) return 16'h8000;
    return v[15:0];
  endfunction

endpackage

// File: rtl/lpc_frame_accum.sv
// Per-frame feature accumulators. Presents the fields of the frame as they
// stand after the current beat, so the closing beat's sample is included in
// the word the top module registers.
module lpc_frame_accum
  import lpc_enc_pkg::*;
#(
  parameter int FRAME_LEN     = 160,
  parameter int ENERGY_SHIFT  = 16,
  parameter int R1_SHIFT      = 16,
  parameter int VOICED_E_MIN  = 16,
  parameter int VOICED_ZC_MAX = 40
) (
  input  logic               ACLK,
  input  logic               ARESET_N,
  input  logic               beat_i,
  input  logic signed [15:0] sample_i,
  input  logic               first_i,
  input  logic               last_i,
  output logic               close_o,
  output feat_t              feat_o
);

  logic        [15:0]      cnt_q, cnt_base, cnt_d;
  logic        [15:0]      peak_q, peak_base, peak_d;
  logic        [ACC_W-1:0] e_q, e_base, e_d;
  logic signed [ACC_W-1:0] r1_q, r1_base, r1_d;
  logic        [15:0]      zc_q, zc_base, zc_d;
  logic signed [15:0]      xp_q;
  logic        [16:0]      xs;
  logic        [15:0]      mag;
  logic        [31:0]      sq;
  logic signed [31:0]      prod;
  logic                    has_prev;
  logic        [15:0]      energy;

  // Fold the current sample into the running frame statistics.
  always_comb begin
    // A start-of-stream beat begins from an empty frame.
    cnt_base  = first_i ? '0 : cnt_q;
    peak_base = first_i ? '0 : peak_q;
    e_base    = first_i ? '0 : e_q;
    r1_base   = first_i ? '0 : r1_q;
    zc_base   = first_i ? '0 : zc_q;
    has_prev  = (cnt_base != 16'd0);

    xs   = {sample_i[15], sample_i};
    mag  = sample_i[15] ? 16'(17'd0 - xs) : 16'(sample_i);
    sq   = $unsigned(32'(sample_i) * 32'(sample_i));
    prod = 32'(sample_i) * 32'(xp_q);

    cnt_d  = cnt_base + 16'd1;
    peak_d = (mag > peak_base) ? mag : peak_base;
    e_d    = e_base + ACC_W'(sq);
    r1_d   = has_prev ? r1_base + ACC_W'(prod) : r1_base;
    zc_d   = zc_base;
    if (has_prev && (sample_i[15] != xp_q[15])) zc_d = zc_base + 16'd1;

    close_o = beat_i && (last_i || (cnt_d == 16'(FRAME_LEN)));

    energy        = sat16u(e_d >> ENERGY_SHIFT);
    feat_o.peak   = peak_d;
    feat_o.energy = energy;
    feat_o.r1     = sat16s(r1_d >>> R1_SHIFT);
    feat_o.zc     = zc_d;
    feat_o.voiced = (energy >= 16'(VOICED_E_MIN)) && (zc_d < 16'(VOICED_ZC_MAX));
  end

  // Accumulator registers: update per beat, clear once the frame is emitted.
  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      cnt_q  <= '0;
      peak_q <= '0;
      e_q    <= '0;
      r1_q   <= '0;
      zc_q   <= '0;
      xp_q   <= '0;
    end else if (beat_i) begin
      xp_q <= sample_i;
      if (close_o) begin
        cnt_q  <= '0;
        peak_q <= '0;
        e_q    <= '0;
        r1_q   <= '0;
        zc_q   <= '0;
      end else begin
        cnt_q  <= cnt_d;
        peak_q <= peak_d;
        e_q    <= e_d;
        r1_q   <= r1_d;
        zc_q   <= zc_d;
      end
    end
  end

endmodule

// File: rtl/lpc_frame_encoder.sv
// LPC analysis front end: slices a PCM sample stream into frames and emits
// one packed 80-bit feature word per frame through a single output register.
// Optional build macro LPC_PREEMPH_EN inserts a registered pre-emphasis
// stage (y = x - pe + (pe >>> 4)) ahead of the accumulators.
module lpc_frame_encoder
  import lpc_enc_pkg::*;
#(
  parameter int FRAME_LEN     = 160,
  parameter int ENERGY_SHIFT  = 16,
  parameter int R1_SHIFT      = 16,
  parameter int VOICED_E_MIN  = 16,
  parameter int VOICED_ZC_MAX = 40
) (
  input  logic              ACLK,
  input  logic              ARESET_N,
  input  logic [15:0]       TDATA,
  input  logic              TVALID,
  input  logic              TLAST,
  input  logic              TUSER,
  output logic              TREADY,
  output logic              OUT_VALID,
  output logic              OUT_LAST,
  output logic [OUT_W-1:0]  OUT_DATA,
  input  logic              OUT_READY
);

  logic               advance;
  logic               accept;
  logic               beat;
  logic signed [15:0] acc_sample;
  logic               acc_first;
  logic               acc_last;
  logic               close;
  feat_t              feat;

  logic [IDX_W-1:0]   idx_q, idx_d, frame_idx;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;

  // The output register can be refilled in the cycle it is drained.
  assign advance = !out_valid_q || OUT_READY;
  assign TREADY  = advance;
  assign accept  = TVALID && advance;

`ifdef LPC_PREEMPH_EN
  logic               st_valid_q, st_first_q, st_last_q;
  logic signed [15:0] st_data_q;
  logic signed [15:0] pe_q, pe_eff;
  logic signed [17:0] y;

  // Pre-emphasis against the previous raw sample; a new stream starts clean.
  always_comb begin
    pe_eff = TUSER ? 16'sd0 : pe_q;
    y      = 18'($signed(TDATA)) - 18'(pe_eff) + 18'(pe_eff >>> 4);
  end

  // Pipeline stage moves only when the accumulators can take its beat.
  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      st_valid_q <= 1'b0;
      st_first_q <= 1'b0;
      st_last_q  <= 1'b0;
      st_data_q  <= '0;
      pe_q       <= '0;
    end else if (advance) begin
      st_valid_q <= accept;
      if (accept) begin
        st_data_q  <= sat16s(ACC_W'(y));
        st_first_q <= TUSER;
        st_last_q  <= TLAST;
        pe_q       <= $signed(TDATA);
      end
    end
  end

  assign beat       = st_valid_q && advance;
  assign acc_sample = st_data_q;
  assign acc_first  = st_first_q;
  assign acc_last   = st_last_q;
`else
  assign beat       = accept;
  assign acc_sample = $signed(TDATA);
  assign acc_first  = TUSER;
  assign acc_last   = TLAST;
`endif

  lpc_frame_accum #(
    .FRAME_LEN     (FRAME_LEN),
    .ENERGY_SHIFT  (ENERGY_SHIFT),
    .R1_SHIFT      (R1_SHIFT),
    .VOICED_E_MIN  (VOICED_E_MIN),
    .VOICED_ZC_MAX (VOICED_ZC_MAX)
  ) u_accum (
    .ACLK     (ACLK),
    .ARESET_N (ARESET_N),
    .beat_i   (beat),
    .sample_i (acc_sample),
    .first_i  (acc_first),
    .last_i   (acc_last),
    .close_o  (close),
    .feat_o   (feat)
  );

  // Frame index bookkeeping and output word assembly.
  always_comb begin
    frame_idx   = acc_first ? '0 : idx_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    if (close) begin
      // A stream end restarts numbering; otherwise wrap naturally at 8 bits.
      idx_d       = acc_last ? '0 : frame_idx + 8'd1;
      out_valid_d = 1'b1;
      out_last_d  = acc_last;
      out_data_d  = '0;
      out_data_d[IDX_LSB    +: IDX_W]   = frame_idx;
      out_data_d[PEAK_LSB   +: FIELD_W] = feat.peak;
      out_data_d[ENERGY_LSB +: FIELD_W] = feat.energy;
      out_data_d[R1_LSB     +: FIELD_W] = feat.r1;
      out_data_d[ZC_LSB     +: FIELD_W] = feat.zc;
      out_data_d[VOICED_BIT]            = feat.voiced;
    end else begin
      if (beat && acc_first) idx_d = '0;
      if (OUT_READY) out_valid_d = 1'b0;
    end
  end

  // Output register and frame index state.
  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_LAST  = out_last_q;
  assign OUT_DATA  = out_data_q;

endmodule

// File: tb/tb_lpc_frame_encoder.sv
// Bench for lpc_frame_encoder (default build): a frame-level reference model
// kept as a queue of samples, a per-cycle output compare, directed scenarios
// pinned with hand-computed words, and randomized streams.
module tb_lpc_frame_encoder;

  localparam int FRAME_LEN = 160;

  logic        ACLK = 1'b0;
  logic        ARESET_N = 1'b0;
  logic [15:0] TDATA = '0;
  logic        TVALID = 1'b0;
  logic        TLAST = 1'b0;
  logic        TUSER = 1'b0;
  logic        TREADY;
  logic        OUT_VALID;
  logic        OUT_LAST;
  logic [79:0] OUT_DATA;
  logic        OUT_READY = 1'b1;

  int checks = 0;
  int errors = 0;

  // 0: always ready, 1: random ready, 2: held not-ready
  int rmode = 0;

  int          fq[$];
  int          m_idx = 0;
  logic        m_valid = 1'b0;
  logic        m_last = 1'b0;
  logic [79:0] m_data = '0;
  logic [80:0] mlog[$];
  int          hs_cnt = 0;
  int          hs_last = 0;

  lpc_frame_encoder #(
    .FRAME_LEN     (FRAME_LEN),
    .ENERGY_SHIFT  (16),
    .R1_SHIFT      (16),
    .VOICED_E_MIN  (16),
    .VOICED_ZC_MAX (40)
  ) lpc_encoder (
    .ACLK      (ACLK),
    .ARESET_N  (ARESET_N),
    .TDATA     (TDATA),
    .TVALID    (TVALID),
    .TLAST     (TLAST),
    .TUSER     (TUSER),
    .TREADY    (TREADY),
    .OUT_VALID (OUT_VALID),
    .OUT_LAST  (OUT_LAST),
    .OUT_DATA  (OUT_DATA),
    .OUT_READY (OUT_READY)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [80:0] act, input logic [80:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Feature word computed directly from the frame's sample list.
  function automatic logic [79:0] make_word(input int idx);
    longint e = 0;
    longint r = 0;
    longint en, r1v;
    int pk = 0;
    int zc = 0;
    logic v;
    for (int i = 0; i < fq.size(); i++) begin
      int a = (fq[i] < 0) ? -fq[i] : fq[i];
      if (a > pk) pk = a;
      e += longint'(fq[i]) * fq[i];
      if (i > 0) begin
        r += longint'(fq[i]) * fq[i-1];
        if ((fq[i] < 0) != (fq[i-1] < 0)) zc++;
      end
    end
    en  = e / 65536;
    if (en > 65535) en = 65535;
    r1v = r >>> 16;
    if (r1v > 32767) r1v = 32767;
    if (r1v < -32768) r1v = -32768;
    v = (en >= 16) && (zc < 40);
    return {8'(idx), 16'(pk), 16'(en), 16'(r1v), 16'(zc), 7'd0, v};
  endfunction

  task automatic model_reset();
    fq.delete();
    m_idx   = 0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_data  = '0;
  endtask

  // Advance the model across the coming rising edge using the current inputs.
  task automatic model_step();
    logic acc, cl, lst;
    logic [79:0] w;
    acc = TVALID && (!m_valid || OUT_READY);
    cl  = 1'b0;
    lst = 1'b0;
    w   = '0;
    if (acc) begin
      if (TUSER) begin
        fq.delete();
        m_idx = 0;
      end
      fq.push_back(int'($signed(TDATA)));
      if (TLAST || fq.size() == FRAME_LEN) begin
        w   = make_word(m_idx);
        cl  = 1'b1;
        lst = TLAST;
        fq.delete();
        m_idx = TLAST ? 0 : (m_idx + 1) % 256;
      end
    end
    if (cl) begin
      m_valid = 1'b1;
      m_data  = w;
      m_last  = lst;
      mlog.push_back({lst, w});
    end else if (OUT_READY) begin
      m_valid = 1'b0;
    end
  endtask

  // Per-cycle compare of the DUT against the model, away from the active edge.
  always @(negedge ACLK) begin
    if (!ARESET_N) begin
      model_reset();
      chk("rst_out_valid", 81'(OUT_VALID), 81'(0));
      chk("rst_out_last", 81'(OUT_LAST), 81'(0));
      chk("rst_out_data", 81'(OUT_DATA), 81'(0));
    end else begin
      chk("tready", 81'(TREADY), 81'(!m_valid || OUT_READY));
      chk("out_valid", 81'(OUT_VALID), 81'(m_valid));
      if (m_valid) begin
        chk("out_data", 81'(OUT_DATA), 81'(m_data));
        chk("out_last", 81'(OUT_LAST), 81'(m_last));
      end
      if (OUT_VALID && OUT_READY) begin
        hs_cnt++;
        if (OUT_LAST) hs_last++;
      end
      model_step();
    end
  end

  always @(posedge ACLK) begin
    #1;
    case (rmode)
      0: OUT_READY = 1'b1;
      1: OUT_READY = ($urandom_range(0, 3) != 0);
      default: OUT_READY = 1'b0;
    endcase
  end

  // Present one beat and hold it until accepted; entered and left at posedge+1.
  task automatic send(input logic [15:0] x, input logic u, input logic l);
    TDATA  = x;
    TUSER  = u;
    TLAST  = l;
    TVALID = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge ACLK);
      if (TREADY) begin
        @(posedge ACLK);
        #1;
        TVALID = 1'b0;
        TUSER  = 1'b0;
        TLAST  = 1'b0;
        return;
      end
      @(posedge ACLK);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: beat not accepted within 2000 cycles");
    TVALID = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic drain();
    rmode = 0;
    idle(4);
  endtask

  task automatic pin_last(input string name, input logic [80:0] exp);
    if (mlog.size() == 0) chk({name, "_present"}, 81'(0), 81'(1));
    else chk(name, mlog[$], exp);
  endtask

  function automatic logic [15:0] rand_sample();
    case ($urandom_range(0, 3))
      0: return 16'($urandom);
      1: return 16'($signed($urandom_range(0, 100)) - 50);
      2: return ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
      default: return 16'($signed($urandom_range(0, 6000)) - 3000);
    endcase
  endfunction

  initial begin
    int w0, l0;
    idle(3);
    ARESET_N = 1'b1;
    idle(2);

    // Constant +100 frame
    for (int i = 0; i < 160; i++) send(16'd100, i == 0, 1'b0);
    drain();
    pin_last("const100_word", {1'b0, 8'd0, 16'd100, 16'd24, 16'd24, 16'd0, 7'd0, 1'b1});

    // Alternating +/-1000 frame
    for (int i = 0; i < 160; i++) send((i % 2) ? 16'hFC18 : 16'd1000, i == 0, 1'b0);
    drain();
    pin_last("alt1000_word", {1'b0, 8'd0, 16'd1000, 16'd2441, 16'hF685, 16'd159, 7'd0, 1'b0});

    // 1920-sample stream closed by TLAST, random gaps and backpressure
    w0 = hs_cnt;
    l0 = hs_last;
    rmode = 1;
    for (int i = 0; i < 1920; i++) begin
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      send(rand_sample(), i == 0, i == 1919);
    end
    drain();
    chk("stream_words", 81'(hs_cnt - w0), 81'(12));
    chk("stream_lasts", 81'(hs_last - l0), 81'(1));
    if (mlog.size() > 0) chk("stream_final_idx", 81'(mlog[$][80:72]), 81'({1'b1, 8'd11}));

    // Output held off for 20 cycles with a word pending
    w0 = hs_cnt;
    fork
      begin
        for (int i = 0; i < 320; i++) send(rand_sample(), i == 0, 1'b0);
      end
      begin
        rmode = 2;
        for (int n = 0; n < 2000 && !OUT_VALID; n++) @(negedge ACLK);
        chk("stall_word_pending", 81'(OUT_VALID), 81'(1));
        idle(20);
        rmode = 0;
      end
    join
    drain();
    chk("stall_words", 81'(hs_cnt - w0), 81'(2));

    // Partial frame of full-scale samples closed by TLAST
    for (int i = 0; i < 10; i++) send(16'h7FFF, i == 0, i == 9);
    drain();
    pin_last("partial_word", {1'b1, 8'd0, 16'd32767, 16'hFFFF, 16'h7FFF, 16'd0, 7'd0, 1'b1});
    for (int i = 0; i < 5; i++) send(16'd3, i == 0, i == 4);
    drain();
    pin_last("restart_idx", {1'b1, 8'd0, 16'd3, 16'd0, 16'd0, 16'd0, 7'd0, 1'b0});

    // Single-beat frame with TUSER and TLAST together
    send(16'hFFF6, 1'b1, 1'b1);
    drain();
    pin_last("single_beat", {1'b1, 8'd0, 16'd10, 16'd0, 16'd0, 16'd0, 7'd0, 1'b0});

    // Reset in the middle of a frame
    for (int i = 0; i < 50; i++) send(16'hEC78, i == 0, 1'b0);
    ARESET_N = 1'b0;
    idle(1);
    ARESET_N = 1'b1;
    for (int i = 0; i < 160; i++) send(16'd200, 1'b0, 1'b0);
    drain();
    pin_last("post_reset_word", {1'b0, 8'd0, 16'd200, 16'd97, 16'd97, 16'd0, 7'd0, 1'b1});

    // Randomized streams with occasional restarts and random backpressure
    rmode = 1;
    for (int s = 0; s < 8; s++) begin
      int len = $urandom_range(1, 400);
      logic end_last = ($urandom_range(0, 1) != 0);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 2));
        send(rand_sample(), (i == 0) || ($urandom_range(0, 199) == 0),
             end_last && (i == len - 1));
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
